// File: rtl/piso_stream.sv
// Parallel-in / serial-out stream adapter: pops one wide word from a FWFT FIFO
// and presents it as N narrower slices under a valid/ready handshake.
module piso_stream #(
  parameter int INPUT_SIZE  = 256,
  parameter int OUTPUT_SIZE = 64,
  parameter int MSB_FIRST   = 1,
  localparam int N          = INPUT_SIZE / OUTPUT_SIZE,
  localparam int IDX_W      = (N > 2) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INPUT_SIZE-1:0]  i_parallel,
  input  logic                   fifo_empty,
  output logic                   fifo_re,
  output logic [OUTPUT_SIZE-1:0] o_serial,
  output logic                   valid,
  input  logic                   o_ready,
  output logic                   o_last,
  output logic [IDX_W-1:0]       o_idx
);

  if ((INPUT_SIZE % OUTPUT_SIZE) != 0 || N < 2) begin : g_bad_cfg
    $error("piso_stream: INPUT_SIZE must be an integer multiple (>=2) of OUTPUT_SIZE");
  end

  // Handshake: a slice transfers on a ce-enabled cycle where valid and o_ready
  // are both high; valid never drops until that transfer happens.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [INPUT_SIZE-1:0]  word_q, word_d;
  logic [OUTPUT_SIZE-1:0] serial_q, serial_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   last_q, last_d;
  logic                   accept;
  logic                   load;

  // Slice k in emission order; MSB_FIRST reverses the position within the word.
  function automatic logic [OUTPUT_SIZE-1:0] slice_of(input logic [INPUT_SIZE-1:0] w,
                                                      input logic [IDX_W-1:0]      k);
    int pos;
    pos = (MSB_FIRST != 0) ? (N - 1 - int'(k)) : int'(k);
    return OUTPUT_SIZE'(w >> (pos * OUTPUT_SIZE));
  endfunction

  assign valid   = (state_q == SHIFT);
  assign accept  = ce & valid & o_ready;
  assign load    = ce & ~fifo_empty & ((state_q == IDLE) | (accept & last_q));
  assign fifo_re = load & ~rst;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    serial_d = serial_q;
    idx_d    = idx_q;
    last_d   = last_q;
    if (load) begin
      state_d  = SHIFT;
      word_d   = i_parallel;
      idx_d    = '0;
      serial_d = slice_of(i_parallel, IDX_W'(0));
      last_d   = 1'b0;
    end else if (accept) begin
      if (last_q) begin
        // Drained with nothing queued: o_serial deliberately keeps its last slice.
        state_d = IDLE;
        idx_d   = '0;
        last_d  = 1'b0;
      end else begin
        idx_d    = idx_q + IDX_W'(1);
        serial_d = slice_of(word_q, idx_q + IDX_W'(1));
        last_d   = ((idx_q + IDX_W'(1)) == IDX_W'(N - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      serial_q <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else if (ce) begin
      state_q  <= state_d;
      word_q   <= word_d;
      serial_q <= serial_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

  assign o_serial = serial_q;
  assign o_last   = last_q;
  assign o_idx    = idx_q;

endmodule
